bus_gnrtr_n_rbtr: RTL and testbench
===================================

# bus_gnrtr_n_rbtr

Shared-bus generator and arbiter connecting `drvrs` device FIFOs. Each cycle of service selects one device with a pending packet by round-robin, pops the packet from that device's FIFO and pushes it to the destination device(s) encoded in the packet header, including a broadcast ID. It is the DUT of the bus verification environment, driven through `bus_if` by the driver/monitor agents.

## Interface

Parameters:
- `drvrs`, default 4: number of attached devices (2–255).
- `pckg_sz`, default 16: packet width in bits (≥ 9).
- `broadcast`, default 8'hFF: destination ID meaning "all devices".

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `pndng`, input, `drvrs`: bit i high means device i's FIFO is non-empty.
- `D_pop`, input, `drvrs*pckg_sz`: head word of device i's FIFO in slice [i*pckg_sz +: pckg_sz]. First-word-fall-through; valid while `pndng[i]` is high.
- `pop`, output, `drvrs`: one-cycle pulse that consumes the head of device i's FIFO.
- `push`, output, `drvrs`: one-cycle pulse that writes `D_push` slice i into device i.
- `D_push`, output, `drvrs*pckg_sz`: delivered packet, identical in every slice.

## Operation

- Packet format: [pckg_sz-1 : pckg_sz-8] = destination ID; the remaining low bits are the payload, carried unmodified.
- FSM states:
  - IDLE: if any `pndng` bit is set, latch winner `w` = first set bit searching upward from (last winner + 1) modulo `drvrs`, then go to POP. Otherwise stay in IDLE.
  - POP: assert `pop[w]`. Capture `D_pop` slice w into the packet register. Go to PUSH.
  - PUSH: drive the captured packet on all `D_push` slices and assert `push` per the destination rule below. Go to IDLE.
- Destination rule:
  - ID < `drvrs`: `push[ID]` only. Self-addressed packets (ID == w) are delivered to the source.
  - ID == `broadcast`: `push` to every device except w.
  - Any other ID: packet dropped. No `push`; the pop still happens.
- Round-robin pointer after reset = `drvrs`-1, so device 0 has first priority. The pointer updates only when a winner is latched.
- Only one packet is in flight at a time.

## Timing

- Reset (asynchronous assert, synchronous release): `pop`=0, `push`=0, `D_push`=0, state IDLE, pointer = `drvrs`-1, packet register = 0.
- Reset asserted mid-transaction aborts it: no `push` is issued and any pending `pop` is deasserted immediately.
- Latency: `pndng` seen high at edge N → `pop` high during cycle N+1 → `push` high during cycle N+2.
- Throughput: one packet per 3 cycles. Back-to-back requests re-arbitrate in IDLE.
- `pop` and `push` are never asserted for more than one cycle per packet.
- `D_push` holds the last delivered packet until the next PUSH.
- Simultaneous `pndng` bits: exactly one winner per transaction; a continuously requesting device waits at most `drvrs`-1 transactions.
- `pndng` changes during POP/PUSH have no effect until the next IDLE.

## Configuration

- `BUS_BROADCAST_EN` defined: broadcast ID handled as above.
- Undefined: the broadcast ID is treated as an invalid destination and the packet is dropped. The `broadcast` parameter is unused.

## Test plan

- Reset: hold `reset`=0 for 3 cycles with `pndng`=4'hF → `pop`=0, `push`=0, `D_push`=0 throughout.
- Unicast: device 1 pending with 16'h02AB → `pop`=4'b0010 one cycle later, then `push`=4'b0100 with every `D_push` slice = 16'h02AB.
- Broadcast (macro on): device 3 sends 16'hFF5A → `push`=4'b0111, data 16'hFF5A. Macro off → no `push`.
- Round-robin: `pndng`=4'hF held, FIFOs never empty → `pop` sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- Invalid destination: device 0 sends 16'h0711 with drvrs=4 → `pop`=4'b0001, no `push`, `D_push` unchanged.
- Mid-transaction reset: assert `reset`=0 during POP → `pop` drops asynchronously, no `push`; after release, arbitration restarts at device 0.

Source files
------------

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus arbiter: round-robin picks one pending device FIFO, pops its head, pushes it to its destination(s).
// Define BUS_BROADCAST_EN to deliver the broadcast ID to every device except the source; otherwise it is dropped.
module bus_gnrtr_n_rbtr #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push
);

  localparam int unsigned IdW  = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int unsigned DstW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [drvrs-1:0]   push_q, push_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d;

  logic [IdW-1:0]     win_c;
  logic               found_c;
  int unsigned        dist_c, best_c;
  logic [pckg_sz-1:0] head_c;
  logic [DstW-1:0]    dst_c;
  logic [drvrs-1:0]   dmask_c;

  // Round-robin: nearest pending device above the last winner, wrapping; the last winner itself is farthest.
  always_comb begin
    found_c = 1'b0;
    win_c   = ptr_q;
    best_c  = drvrs + 1;
    dist_c  = 0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      dist_c = (i > 32'(ptr_q)) ? (i - 32'(ptr_q)) : (i + drvrs - 32'(ptr_q));
      if (pndng[i] && (dist_c < best_c)) begin
        best_c  = dist_c;
        win_c   = IdW'(i);
        found_c = 1'b1;
      end
    end
  end

  // Head word of the current winner and its delivery mask.
  always_comb begin
    head_c = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      if (32'(ptr_q) == i) head_c = D_pop[i*pckg_sz +: pckg_sz];
    end
    dst_c   = head_c[pckg_sz-1 -: DstW];
    dmask_c = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
`ifdef BUS_BROADCAST_EN
      if (dst_c == broadcast) dmask_c[i] = (i != 32'(ptr_q));
      else                    dmask_c[i] = (32'(dst_c) == i);
`else
      dmask_c[i] = (dst_c != broadcast) && (32'(dst_c) == i);
`endif
    end
  end

  // Next-state logic; the packet register only loads when something is delivered so D_push holds otherwise.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pop_d   = '0;
    push_d  = '0;
    pkt_d   = pkt_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          ptr_d = win_c;
          for (int unsigned i = 0; i < drvrs; i++) pop_d[i] = (32'(win_c) == i);
          state_d = POP;
        end
      end
      POP: begin
        push_d = dmask_c;
        if (|dmask_c) pkt_d = head_c;
        state_d = PUSH;
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IdW'(drvrs - 1);
      pop_q   <= '0;
      push_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      pkt_q   <= pkt_d;
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign D_push = {drvrs{pkt_q}};

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Randomized bench for bus_gnrtr_n_rbtr with a transaction-level reference model and per-cycle compare.
module tb_bus_gnrtr_n_rbtr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   pndng, pop, push;
  logic [N*W-1:0] d_pop, d_push;

  always #5 clk = ~clk;

  bus_gnrtr_n_rbtr #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(rst), .pndng(pndng), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(d_push)
  );

  logic [W-1:0] q [N][$];
  int           total = 0, bad = 0;
  logic [N-1:0] exp_pop, exp_push, nx_pop, nx_push;
  logic [W-1:0] exp_dpush, nx_dpush;
  int           m_phase, m_ptr, pend_pop;
  bit           chk_en = 0, keep_full = 0, rand_fill = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pop", 64'(pop), 64'(exp_pop));
      check("push", 64'(push), 64'(exp_push));
      check("d_push", 64'(d_push), 64'({N{exp_dpush}}));
    end
  end

  function automatic logic [W-1:0] rand_pkt();
    logic [7:0] id;
    int s;
    s = $urandom_range(0, 5);
    if (s < 4)       id = 8'(s);
    else if (s == 4) id = 8'hFF;
    else             id = 8'($urandom_range(N, 254));
    return {id, 8'($urandom)};
  endfunction

  // Delivery set for a packet sent by device src.
  function automatic logic [N-1:0] dest(input logic [W-1:0] p, input int src);
    int id;
    logic [N-1:0] m;
    id = int'(p[W-1:W-8]);
    m  = '0;
    if (id == 255) begin
`ifdef BUS_BROADCAST_EN
      m = '1;
      m[src] = 1'b0;
`endif
    end else if (id < N) begin
      m[id] = 1'b1;
    end
    return m;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (q[i].size() > 0);
      d_pop[i*W +: W] = pndng[i] ? q[i][0] : W'($urandom);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = N - 1; pend_pop = -1;
    nx_pop = '0; nx_push = '0; nx_dpush = '0;
    exp_pop = '0; exp_push = '0; exp_dpush = '0;
  endtask

  // Predict outputs after the next edge from the inputs now being presented.
  task automatic predict();
    bit found;
    nx_pop  = '0;
    nx_push = '0;
    if (!rst) return;
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int d;
          d = (m_ptr + k) % N;
          if (!found && pndng[d]) begin
            found = 1;
            m_ptr = d;
          end
        end
        if (found) begin
          nx_pop[m_ptr] = 1'b1;
          m_phase = 1;
        end
      end
      1: begin
        nx_push = dest(q[m_ptr][0], m_ptr);
        if (|nx_push) nx_dpush = q[m_ptr][0];
        pend_pop = m_ptr;
        m_phase  = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pend_pop >= 0) begin
      void'(q[pend_pop].pop_front());
      pend_pop = -1;
    end
    exp_pop = nx_pop; exp_push = nx_push; exp_dpush = nx_dpush;
    if (keep_full) begin
      for (int i = 0; i < N; i++) while (q[i].size() < 3) q[i].push_back(rand_pkt());
    end else if (rand_fill && ($urandom_range(0, 2) == 0)) begin
      q[$urandom_range(0, N - 1)].push_back(rand_pkt());
    end
    drive();
    predict();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
    rst = 1'b1; pndng = '0; d_pop = '0;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    #2 rst = 1'b0;
    model_reset();
    chk_en = 1;
    keep_full = 1;
    repeat (3) step();
    check("rst_pndng", 64'(pndng), 64'h0F);
    check("rst_pop", 64'(pop), 64'h0);
    check("rst_push", 64'(push), 64'h0);
    check("rst_dpush", 64'(d_push), 64'h0);
    keep_full = 0;
    flush();
    drive();
    rst = 1'b1;
    predict();

    // Unicast from device 1 to device 2.
    q[1].push_back(16'h02AB);
    step(); step();
    check("uni_pop", 64'(pop), 64'h2);
    step();
    check("uni_push", 64'(push), 64'h4);
    check("uni_data", 64'(d_push), 64'h02AB02AB02AB02AB);
    step();

    // Broadcast from device 3.
    q[3].push_back(16'hFF5A);
    step(); step();
    check("bc_pop", 64'(pop), 64'h8);
    step();
`ifdef BUS_BROADCAST_EN
    check("bc_push", 64'(push), 64'h7);
    check("bc_data", 64'(d_push), 64'hFF5AFF5AFF5AFF5A);
`else
    check("bc_push", 64'(push), 64'h0);
    check("bc_data", 64'(d_push), 64'h02AB02AB02AB02AB);
`endif
    step();

    // Invalid destination from device 0.
    q[0].push_back(16'h0711);
    step(); step();
    check("inv_pop", 64'(pop), 64'h1);
    step();
    check("inv_push", 64'(push), 64'h0);
`ifdef BUS_BROADCAST_EN
    check("inv_data", 64'(d_push), 64'hFF5AFF5AFF5AFF5A);
`else
    check("inv_data", 64'(d_push), 64'h02AB02AB02AB02AB);
`endif
    step();

    // Reset during POP, then round-robin from device 0 with all FIFOs busy.
    keep_full = 1;
    step(); step();
    check("mrst_pre_pop", 64'(pop), 64'h2);
    rst = 1'b0;
    #1;
    check("mrst_pop_async", 64'(pop), 64'h0);
    model_reset();
    repeat (3) step();
    check("mrst_push", 64'(push), 64'h0);
    check("mrst_dpush", 64'(d_push), 64'h0);
    rst = 1'b1;
    predict();
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr_pop%0d", k), 64'(pop), 64'(rr_exp[k]));
      step(); step();
    end

    // Random traffic with occasional resets.
    keep_full = 0;
    rand_fill = 1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b1;
        predict();
      end
    end
    rand_fill = 0;
    repeat (10) step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
